gen_sweep_ctrl: RTL and testbench

Sequencer that drives the period input of the SPI-configured square-wave generator through a programmed table of steps. Each step holds a period value and a dwell count measured in generator toggles. The block sits between the SPI register receiver (table writes, start/stop) and the generator (period, load strobe, enable, toggle tick). It turns the fixed-frequency generator into a stepped frequency sweep.

---
 rtl/gen_pkg.sv | 21 ++
 rtl/gen_sweep_table.sv | 45 ++++
 rtl/gen_sweep_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_gen_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared definitions for the sweep sequencer: FSM states, default sizes
// and the layout of one sweep table entry.
package gen_pkg;

    localparam int W_DEF       = 16;
    localparam int DEPTH_DEF   = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [W_DEF-1:0]       period;
        logic [DWELL_W_DEF-1:0] dwell;
    } entry_t;

endpackage

// File: rtl/gen_sweep_table.sv
// Sweep step table: DEPTH entries of {period, dwell}, one write port, one
// asynchronous read port plus a fixed tap on entry 0 (sequence head).
module gen_sweep_table
    import gen_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [W-1:0]       wr_period_i,
    input  logic [DWELL_W-1:0] wr_dwell_i,
    input  logic [AW-1:0]      rd_idx_i,
    output logic [W-1:0]       rd_period_o,
    output logic [DWELL_W-1:0] rd_dwell_o,
    output logic [W-1:0]       head_period_o,
    output logic [DWELL_W-1:0] head_dwell_o
);

    logic [W-1:0]       period_q [DEPTH];
    logic [DWELL_W-1:0] dwell_q  [DEPTH];

    // Table storage, cleared asynchronously so a reset also wipes the program
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                period_q[i] <= '0;
                dwell_q[i]  <= '0;
            end
        end else if (wr_en_i) begin
            period_q[wr_addr_i] <= wr_period_i;
            dwell_q[wr_addr_i]  <= wr_dwell_i;
        end
    end

    assign rd_period_o   = period_q[rd_idx_i];
    assign rd_dwell_o    = dwell_q[rd_idx_i];
    assign head_period_o = period_q[0];
    assign head_dwell_o  = dwell_q[0];

endmodule

// File: rtl/gen_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding the square-wave generator.
// Optional replay of the table is built only when GEN_SWEEP_LOOP_EN is defined.
module gen_sweep_ctrl
    import gen_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W-1:0]       wr_period,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic               tick,
    output logic [W-1:0]       period,
    output logic               period_ld,
    output logic               gen_en,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               done
);

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [W-1:0]       period_q, period_d;
    logic               period_ld_q, period_ld_d;
    logic               gen_en_q, gen_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [AW-1:0]      rd_idx_s;
    logic [W-1:0]       rd_period_s, head_period_s;
    logic [DWELL_W-1:0] rd_dwell_s, head_dwell_s;
    logic               last_s;
    logic               from_head_s;
    logic               step_end_s;
    logic               restart_s;

    // The read port always looks one entry ahead; idx wraps naturally at DEPTH
    assign rd_idx_s   = idx_q + AW'(1);
    assign last_s     = (idx_q == AW'(DEPTH - 1));
    assign step_end_s = tick && (tick_cnt_q == (dwell_q - DWELL_W'(1)));

`ifdef GEN_SWEEP_LOOP_EN
    assign restart_s = loop && (head_dwell_s != '0);
`else
    logic unused_loop_s;
    assign unused_loop_s = loop;
    assign restart_s     = 1'b0;
`endif

    gen_sweep_table #(
        .W       (W),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk_i         (clk),
        .reset_i       (reset),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_period_i   (wr_period),
        .wr_dwell_i    (wr_dwell),
        .rd_idx_i      (rd_idx_s),
        .rd_period_o   (rd_period_s),
        .rd_dwell_o    (rd_dwell_s),
        .head_period_o (head_period_s),
        .head_dwell_o  (head_dwell_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop overrides everything, including a same-cycle start
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_cnt_d  = tick_cnt_q;
        from_head_s = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (head_dwell_s != '0)) begin
                        state_d     = ST_LOAD;
                        idx_d       = '0;
                        from_head_s = 1'b1;
                    end else if (start) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end
                ST_RUN: begin
                    if (step_end_s && !last_s && (rd_dwell_s != '0)) begin
                        state_d = ST_LOAD;
                        idx_d   = rd_idx_s;
                    end else if (step_end_s && restart_s) begin
                        state_d     = ST_LOAD;
                        idx_d       = '0;
                        from_head_s = 1'b1;
                    end else if (step_end_s) begin
                        state_d = ST_FIN;
                    end else if (tick) begin
                        tick_cnt_d = tick_cnt_q + DWELL_W'(1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        period_d    = period_q;
        dwell_d     = dwell_q;
        period_ld_d = 1'b0;
        gen_en_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_LOAD: begin
                period_ld_d = 1'b1;
                gen_en_d    = 1'b1;
                busy_d      = 1'b1;
                if (from_head_s) begin
                    period_d = head_period_s;
                    dwell_d  = head_dwell_s;
                end else begin
                    period_d = rd_period_s;
                    dwell_d  = rd_dwell_s;
                end
            end
            ST_RUN: begin
                gen_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Step index, tick counter, latched dwell and output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            tick_cnt_q  <= '0;
            dwell_q     <= '0;
            period_q    <= '0;
            period_ld_q <= 1'b0;
            gen_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            tick_cnt_q  <= tick_cnt_d;
            dwell_q     <= dwell_d;
            period_q    <= period_d;
            period_ld_q <= period_ld_d;
            gen_en_q    <= gen_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign period    = period_q;
    assign period_ld = period_ld_q;
    assign gen_en    = gen_en_q;
    assign busy      = busy_q;
    assign step_idx  = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gen_sweep_ctrl.sv
// Randomized bench for gen_sweep_ctrl against a step-list reference model.
module tb_gen_sweep_ctrl;
    import gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_period;
    logic [7:0]  wr_dwell;
    logic        start, stop, loop, tick;
    logic [15:0] period;
    logic        period_ld, gen_en, busy, done;
    logic [1:0]  step_idx;

    int n_checks = 0;
    int n_fail   = 0;
    entry_t m_tab [4];

    always #5 clk = ~clk;

    gen_sweep_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dwell  (wr_dwell),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .tick      (tick),
        .period    (period),
        .period_ld (period_ld),
        .gen_en    (gen_en),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int p, input int d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_period = 16'(p); wr_dwell = 8'(d);
        cyc();
        wr_en = 1'b0;
        m_tab[a].period = 16'(p);
        m_tab[a].dwell  = 8'(d);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_en"}, gen_en, 0);
        check_eq({tag, "_ld"}, period_ld, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // Plays one sequence from start; stop_at = total ticks before a stop (-1: none)
    task automatic run_seq(input int stop_at, input bit lp);
        int idx, ticks, total, guard, cur_dw, cur_p;
        bit fin, loop_on;
        loop_on = 1'b0;
`ifdef GEN_SWEEP_LOOP_EN
        loop_on = lp;
`endif
        loop = lp;
        start = 1'b1; cyc(); start = 1'b0;
        if (m_tab[0].dwell == 0) begin
            check_eq("empty_done", done, 1);
            check_eq("empty_ld", period_ld, 0);
            check_eq("empty_en", gen_en, 0);
            check_eq("empty_busy", busy, 0);
            cyc();
            check_idle("empty_after");
            return;
        end
        idx = 0; total = 0; guard = 0; fin = 1'b0;
        while (!fin) begin
            cur_dw = int'(m_tab[idx].dwell);
            cur_p  = int'(m_tab[idx].period);
            check_eq("load_ld", period_ld, 1);
            check_eq("load_period", period, cur_p);
            check_eq("load_idx", step_idx, idx);
            check_eq("load_busy", busy, 1);
            check_eq("load_en", gen_en, 1);
            check_eq("load_done", done, 0);
            tick = 1'($urandom_range(0, 1));
            cyc();
            tick = 1'b0;
            ticks = 0;
            while (ticks < cur_dw && !fin) begin
                guard++;
                check_eq("run_ld", period_ld, 0);
                check_eq("run_busy", busy, 1);
                if (guard > 2000) begin
                    check_eq("cycle_budget", guard, 2000);
                    fin = 1'b1;
                end else if (total == stop_at) begin
                    stop = 1'b1; tick = 1'($urandom_range(0, 1));
                    cyc();
                    stop = 1'b0; tick = 1'b0;
                    check_idle("stop");
                    check_eq("stop_period", period, cur_p);
                    cyc();
                    check_idle("stop_after");
                    fin = 1'b1;
                end else begin
                    tick = ($urandom_range(0, 2) != 0);
                    if (!tick && $urandom_range(0, 5) == 0) begin
                        wr_en = 1'b1; wr_addr = 2'(idx);
                        wr_period = 16'($urandom); wr_dwell = 8'($urandom_range(1, 3));
                        m_tab[idx].period = wr_period;
                        m_tab[idx].dwell  = wr_dwell;
                    end
                    cyc();
                    wr_en = 1'b0;
                    if (tick) begin
                        ticks++;
                        total++;
                    end
                    tick = 1'b0;
                end
            end
            if (!fin) begin
                if (idx + 1 < 4 && m_tab[idx + 1].dwell != 0) begin
                    idx = idx + 1;
                end else if (loop_on && m_tab[0].dwell != 0) begin
                    idx = 0;
                end else begin
                    check_eq("fin_done", done, 1);
                    check_eq("fin_busy", busy, 0);
                    check_eq("fin_en", gen_en, 0);
                    check_eq("fin_ld", period_ld, 0);
                    check_eq("fin_period", period, cur_p);
                    cyc();
                    check_idle("fin_after");
                    fin = 1'b1;
                end
            end
        end
        loop = 1'b0;
    endtask

    initial begin
        int sa;
        bit lp;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_period = 16'd0; wr_dwell = 8'd0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; tick = 1'b0;
        for (int i = 0; i < 4; i++) m_tab[i] = '0;
        cyc(); cyc();
        check_idle("reset");
        check_eq("reset_period", period, 0);
        check_eq("reset_idx", step_idx, 0);
        reset = 1'b0;
        cyc();

        // Two-step sweep
        wr(0, 100, 2); wr(1, 50, 3); wr(2, 7, 0); wr(3, 9, 0);
        run_seq(-1, 1'b0);

        // Empty sequence
        wr(0, 10, 0);
        run_seq(-1, 1'b0);

        // All four entries, dwell 1
        for (int a = 0; a < 4; a++) wr(a, 1000 + a, 1);
        run_seq(-1, 1'b0);

        // Loop request on a 2-entry table; stopped after 11 ticks when looping
        wr(0, 300, 2); wr(1, 0, 1); wr(2, 5, 0);
        run_seq(11, 1'b1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check_idle("startstop");
        cyc();
        check_idle("startstop_after");

        // stop during RUN
        wr(0, 20, 3); wr(1, 40, 2);
        run_seq(2, 1'b0);

        // Randomized programs
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < 4; a++) wr(a, int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
            if (m_tab[0].dwell == 0 && $urandom_range(0, 2) != 0) wr(0, 123, 2);
            lp = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
`ifdef GEN_SWEEP_LOOP_EN
            if (lp && sa < 0) sa = int'($urandom_range(8, 20));
`endif
            run_seq(sa, lp);
        end

        // Asynchronous reset mid-sweep
        wr(0, 77, 4); wr(1, 88, 2);
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cyc(); tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_eq("areset_busy", busy, 0);
        check_eq("areset_en", gen_en, 0);
        check_eq("areset_period", period, 0);
        check_eq("areset_ld", period_ld, 0);
        check_eq("areset_done", done, 0);
        for (int i = 0; i < 4; i++) m_tab[i] = '0;
        cyc();
        reset = 1'b0;
        cyc();
        run_seq(-1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
